inv_mix_columns_iter: RTL and testbench
=======================================

// Module: inv_mix_columns_iter
// PURPOSE
//  Iterative AES InvMixColumns engine for the decrypt datapath. Inverse of the forward
//  MixColumns stage: one 128-bit state in, the GF(2^8) inverse-mixed state out.
//  Processes COLS_PER_CYCLE columns per clock from a holding register, with a
//  valid/ready handshake on each side. Sits between inv_shift_rows/inv_sub_bytes and AddRoundKey.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns transformed per BUSY cycle; legal values 1, 2, 4 (anything else: elaboration error)
// PORTS
//  iClk     in   1    sole clock; all state updates on the rising edge
//  iRst     in   1    synchronous, active-high reset
//  iState   in   128  input state [0:127]; byte k = iState[8k+:8]; column c = bytes 4c..4c+3; row r = byte 4c+r
//  iValid   in   1    iState valid
//  oReady   out  1    engine accepts iState this cycle
//  oState   out  128  result state, same byte/column layout as iState
//  oValid   out  1    oState holds a finished result
//  iReady   in   1    downstream accepts oState this cycle
// BEHAVIOUR
//  - Per column (s0..s3 -> t0..t3), GF(2^8) mod x^8+x^4+x^3+x+1:
//    t0=0e*s0^0b*s1^0d*s2^09*s3; t1=09*s0^0e*s1^0b*s2^0d*s3
//    t2=0d*s0^09*s1^0e*s2^0b*s3; t3=0b*s0^0d*s1^09*s2^0e*s3
//  - Multiplies built from xtime chains only (x2, x4, x8 then XOR); no LUTs, no '*' operator.
//  - FSM states IDLE, BUSY, DONE; reset state IDLE.
//    IDLE: oReady=1. iValid=1 -> load iState into work reg, col counter=0, go BUSY.
//    BUSY: each cycle replace columns [cnt..cnt+COLS_PER_CYCLE-1] of work reg in place;
//          cnt+=COLS_PER_CYCLE; on the last group go DONE. oReady=0, oValid=0.
//    DONE: oValid=1, oState stable. iReady=1 -> go IDLE. oReady=0 (no accept in DONE).
//  - Latency: oValid rises exactly 4/COLS_PER_CYCLE cycles after the accepting edge
//    (N=1:4, N=2:2, N=4:1). Min initiation interval = latency+2 cycles.
//  - oState = work register at all times; meaningful only while oValid=1.
//  - Backpressure: DONE held indefinitely while iReady=0; oState/oValid unchanged.
//  - iValid in BUSY/DONE ignored (oReady=0); upstream must hold data per handshake rules.
//  - Column counter 2 bits; wraps to 0 on leaving BUSY; never used outside BUSY.
//  - Reset values: oValid=0, oState=128'h0, counter=0, state IDLE. oReady=0 while iRst=1,
//    1 on the first cycle after reset deassertion.
//  - Reset mid-BUSY or mid-DONE: operation aborted, partial result discarded, no oValid pulse.
//  - iRst has priority over any simultaneous handshake.
// STRUCTURE
//  - Shared package aes_pkg: AES_STATE_W=128, AES_COL_W=32, AES_POLY=8'h1B,
//    function gf_xtime(byte), InvMixColumns coefficient constants 0e/0b/0d/09.
//  - Sub-module inv_mix_column: combinational 32-bit column transform, instantiated
//    COLS_PER_CYCLE times via generate; column select mux driven by counter.
//  - Top: FSM, counter, 128-bit work register, handshake logic.
// TESTING
//  1. Column 8e 4d a1 bc in all 4 columns, iValid=1 -> oValid after 4 cycles (N=1),
//     each column db 13 53 45.
//  2. Mixed columns 9f dc 58 9d | d5 d5 d7 d6 | 4d 7e bd f8 | 01 01 01 01 ->
//     f2 0a 22 5c | d4 d4 d4 d5 | 2d 26 31 4c | 01 01 01 01; repeat for N=2 (lat 2), N=4 (lat 1).
//  3. Backpressure: iReady=0 for 10 cycles in DONE -> oValid stays 1, oState unchanged,
//     oReady=0; iReady=1 -> IDLE next cycle, oReady=1.
//  4. Reset on 2nd BUSY cycle -> oValid never asserts, oState=0; new block after reset
//     completes correctly.
//  5. Round trip: random 1000 states through forward mix_columns then this block ->
//     output equals original; back-to-back iValid held high gives one result per latency+2 cycles.
//  6. iValid pulsed while BUSY with different data -> ignored; result matches first block only.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, the GF(2^8) reduction polynomial, InvMixColumns
// coefficients and the xtime-based byte multiply used by the column transform.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;
  localparam logic [7:0] AES_POLY = 8'h1B;

  // Only the low nibble is ever non-zero for the InvMixColumns matrix.
  localparam logic [3:0] IMC_C0E = 4'hE;
  localparam logic [3:0] IMC_C0B = 4'hB;
  localparam logic [3:0] IMC_C0D = 4'hD;
  localparam logic [3:0] IMC_C09 = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } imc_state_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul_coef(input logic [7:0] b, input logic [3:0] coef);
    logic [7:0] x2, x4, x8;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return ({8{coef[0]}} & b) ^ ({8{coef[1]}} & x2) ^
           ({8{coef[2]}} & x4) ^ ({8{coef[3]}} & x8);
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns of one 32-bit column; byte r of the column is row r.
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] col_i,
  output logic [AES_COL_W-1:0] col_o
);

  logic [7:0] s0, s1, s2, s3;

  assign s0 = col_i[7:0];
  assign s1 = col_i[15:8];
  assign s2 = col_i[23:16];
  assign s3 = col_i[31:24];

  assign col_o[7:0]   = gf_mul_coef(s0, IMC_C0E) ^ gf_mul_coef(s1, IMC_C0B) ^
                        gf_mul_coef(s2, IMC_C0D) ^ gf_mul_coef(s3, IMC_C09);
  assign col_o[15:8]  = gf_mul_coef(s0, IMC_C09) ^ gf_mul_coef(s1, IMC_C0E) ^
                        gf_mul_coef(s2, IMC_C0B) ^ gf_mul_coef(s3, IMC_C0D);
  assign col_o[23:16] = gf_mul_coef(s0, IMC_C0D) ^ gf_mul_coef(s1, IMC_C09) ^
                        gf_mul_coef(s2, IMC_C0E) ^ gf_mul_coef(s3, IMC_C0B);
  assign col_o[31:24] = gf_mul_coef(s0, IMC_C0B) ^ gf_mul_coef(s1, IMC_C0D) ^
                        gf_mul_coef(s2, IMC_C09) ^ gf_mul_coef(s3, IMC_C0E);

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: loads a state, transforms COLS_PER_CYCLE columns per
// cycle in place, then holds the result until the downstream handshake completes.
module inv_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic [AES_STATE_W-1:0] iState,
  input  logic                   iValid,
  output logic                   oReady,
  output logic [AES_STATE_W-1:0] oState,
  output logic                   oValid,
  input  logic                   iReady
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
    $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // For 4 columns per cycle the step truncates to 0 and the last group is group 0.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

  imc_state_e             state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [AES_STATE_W-1:0] work_q, work_d;

  logic [1:0]           col_idx [COLS_PER_CYCLE];
  logic [AES_COL_W-1:0] col_in  [COLS_PER_CYCLE];
  logic [AES_COL_W-1:0] col_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx[g] = cnt_q + 2'(g);
    assign col_in[g]  = work_q[AES_COL_W*int'(col_idx[g]) +: AES_COL_W];

    inv_mix_column u_col (
      .col_i (col_in[g]),
      .col_o (col_out[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    unique case (state_q)
      ST_IDLE: begin
        if (iValid) begin
          work_d  = iState;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          work_d[AES_COL_W*int'(col_idx[g]) +: AES_COL_W] = col_out[g];
        end
        cnt_d = cnt_q + CNT_STEP;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (iReady) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  // Gated with reset so no handshake is offered while the engine is held.
  assign oReady = (state_q == ST_IDLE) && !iRst;
  assign oValid = (state_q == ST_DONE);
  assign oState = work_q;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Bench driving three engines (1, 2 and 4 columns per cycle) against a matrix-level
// GF(2^8) reference of AES MixColumns / InvMixColumns.
module tb_inv_mix_columns_iter;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0][127:0] st;
  logic [2:0][127:0] os;
  logic [2:0]       vin, rin, ordy, ov;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) u_dut1 (
    .iClk(clk), .iRst(rst), .iState(st[0]), .iValid(vin[0]), .oReady(ordy[0]),
    .oState(os[0]), .oValid(ov[0]), .iReady(rin[0]));
  inv_mix_columns_iter #(.COLS_PER_CYCLE(2)) u_dut2 (
    .iClk(clk), .iRst(rst), .iState(st[1]), .iValid(vin[1]), .oReady(ordy[1]),
    .oState(os[1]), .oValid(ov[1]), .iReady(rin[1]));
  inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) u_dut4 (
    .iClk(clk), .iRst(rst), .iState(st[2]), .iValid(vin[2]), .oReady(ordy[2]),
    .oState(os[2]), .oValid(ov[2]), .iReady(rin[2]));

  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] a, p;
    a = a_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = (a << 1) ^ (a[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix multiply per column; row r coefficient for byte j is base[(j-r) mod 4].
  function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] base);
    logic [127:0] t;
    logic [7:0]   acc;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gf_mul(s[8*(4*c+j) +: 8], base[8*(3-((j-r+4)%4)) +: 8]);
        end
        t[8*(4*c+r) +: 8] = acc;
      end
    end
    return t;
  endfunction

  function automatic logic [127:0] inv_model(input logic [127:0] s);
    return mix(s, 32'h0E0B0D09);
  endfunction

  function automatic logic [127:0] fwd_model(input logic [127:0] s);
    return mix(s, 32'h02030101);
  endfunction

  function automatic logic [31:0] col(input logic [7:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on engine d: latency, result, optional hold in DONE, optional
  // stray iValid with other data while BUSY, then release back to IDLE.
  task automatic do_block(input int d, input logic [127:0] data, input logic [127:0] exp,
                          input int hold, input bit glitch, input string tag);
    int lat;
    lat = 4 >> d;
    chk({tag, "_rdy_idle"}, ordy[d], 1);
    st[d]  = data;
    vin[d] = 1'b1;
    rin[d] = 1'b0;
    @(negedge clk);
    if (glitch) st[d] = ~data;
    else vin[d] = 1'b0;
    for (int k = 0; k < lat; k++) begin
      chk({tag, "_vld_early"}, ov[d], 0);
      chk({tag, "_rdy_busy"}, ordy[d], 0);
      @(negedge clk);
      vin[d] = 1'b0;
    end
    chk({tag, "_vld"}, ov[d], 1);
    chk({tag, "_data"}, os[d], exp);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, "_hold_vld"}, ov[d], 1);
      chk({tag, "_hold_data"}, os[d], exp);
      chk({tag, "_hold_rdy"}, ordy[d], 0);
    end
    rin[d] = 1'b1;
    @(negedge clk);
    rin[d] = 1'b0;
    chk({tag, "_rel_vld"}, ov[d], 0);
    chk({tag, "_rel_rdy"}, ordy[d], 1);
  endtask

  initial begin
    logic [127:0] t1, e1, t2, e2, r;
    logic [2:0][127:0] pend;
    int acc[3], res[3], last[3];
    int cyc;

    rst = 1'b1;
    vin = '0;
    rin = '0;
    st  = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_rdy", ordy[d], 0);
      chk("rst_vld", ov[d], 0);
      chk("rst_data", os[d], 0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk("post_rst_rdy", ordy[d], 1);

    t1 = {4{col(8'h8e, 8'h4d, 8'ha1, 8'hbc)}};
    e1 = {4{col(8'hdb, 8'h13, 8'h53, 8'h45)}};
    t2 = {col(8'h01, 8'h01, 8'h01, 8'h01), col(8'h4d, 8'h7e, 8'hbd, 8'hf8),
          col(8'hd5, 8'hd5, 8'hd7, 8'hd6), col(8'h9f, 8'hdc, 8'h58, 8'h9d)};
    e2 = {col(8'h01, 8'h01, 8'h01, 8'h01), col(8'h2d, 8'h26, 8'h31, 8'h4c),
          col(8'hd4, 8'hd4, 8'hd4, 8'hd5), col(8'hf2, 8'h0a, 8'h22, 8'h5c)};

    for (int d = 0; d < 3; d++) begin
      do_block(d, t1, e1, 0, 1'b0, "vec1");
      do_block(d, t2, e2, 0, 1'b0, "vec2");
    end

    r = rnd128();
    do_block(0, r, inv_model(r), 10, 1'b0, "bp_n1");
    r = rnd128();
    do_block(2, r, inv_model(r), 10, 1'b0, "bp_n4");

    for (int d = 0; d < 3; d++) begin
      r = rnd128();
      do_block(d, r, inv_model(r), 0, 1'b1, "busy_ivalid");
    end

    // Reset during the second BUSY cycle of the 1- and 2-column engines.
    st[0]  = rnd128();
    st[1]  = st[0];
    vin[0] = 1'b1;
    vin[1] = 1'b1;
    @(negedge clk);
    vin = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("midrst_vld", ov[d], 0);
      chk("midrst_data", os[d], 0);
      chk("midrst_rdy", ordy[d], 0);
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("abort_vld0", ov[0], 0);
      chk("abort_vld1", ov[1], 0);
    end
    r = rnd128();
    do_block(0, r, inv_model(r), 0, 1'b0, "after_rst_n1");
    r = rnd128();
    do_block(1, r, inv_model(r), 0, 1'b0, "after_rst_n2");

    // Round trip with iValid/iReady held high: forward MixColumns then the engine.
    for (int d = 0; d < 3; d++) begin
      acc[d]  = 0;
      res[d]  = 0;
      last[d] = 0;
      pend[d] = '0;
    end
    rin = 3'b111;
    cyc = 0;
    while ((res[0] < 1000 || res[1] < 1000 || res[2] < 1000) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 3; d++) begin
        if (ov[d]) begin
          chk("roundtrip", os[d], pend[d]);
          res[d]++;
        end
        if (ordy[d]) begin
          if (acc[d] < 1000) begin
            if (acc[d] > 0) chk("interval", 128'(cyc - last[d]), 128'((4 >> d) + 2));
            last[d] = cyc;
            acc[d]++;
            pend[d] = rnd128();
            st[d]   = fwd_model(pend[d]);
            vin[d]  = 1'b1;
          end else begin
            vin[d] = 1'b0;
          end
        end
      end
    end
    vin = '0;
    rin = '0;
    for (int d = 0; d < 3; d++) chk("roundtrip_count", 128'(res[d]), 128'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
